goldschmidt_iter_ff: RTL

//  Iterative Goldschmidt divider core. It sits directly upstream of normalize_ff and computes A/B for IEEE-754 single operands.
//  It unpacks both operands and runs ITER refinement steps on one shared multiplier.
//  It delivers sign, biased exponent and a Q2.46 quotient mantissa in the {S_in,E_in,P_in} format that normalize_ff consumes.

---
 rtl/gd_pkg.sv | 22 ++
 rtl/fp_unpack.sv | 18 +
 rtl/goldschmidt_iter_ff.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/gd_pkg.sv
// Shared types and constants for the Goldschmidt divider slice.
package gd_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 24;
    localparam int P_W      = 48;
    localparam logic [P_W-1:0] Q_ONE_P = 48'h400000000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_N = 2'd1,
        MUL_D = 2'd2,
        DONE  = 2'd3
    } gd_state_e;

    // 2.0 - x in Q2.fw; x is zero-extended to 48 bits, caller keeps the low fw+2 bits.
    function automatic logic [47:0] two_minus(input logic [47:0] x, input int fw);
        return (48'd1 << (fw + 1)) - x;
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits an IEEE-754 single into sign, exponent and mantissa with hidden bit.
// Exponent zero (zero or denormal) is reported as is_zero and treated as zero.
module fp_unpack
    import gd_pkg::*;
(
    input  logic [31:0]       x_i,
    output logic              sign_o,
    output logic [EXP_W-1:0]  exp_o,
    output logic [MANT_W-1:0] mant_o,
    output logic              is_zero_o
);

    assign sign_o    = x_i[31];
    assign exp_o     = x_i[30:23];
    assign mant_o    = {1'b1, x_i[22:0]};
    assign is_zero_o = (x_i[30:23] == 8'd0);

endmodule

// File: rtl/goldschmidt_iter_ff.sv
// Iterative Goldschmidt divider: A/B for IEEE-754 singles, one shared multiplier,
// result as sign / biased exponent / Q2.46 mantissa for the normalizer.
//
// state | meaning
// IDLE  | waiting for start, operands loaded on start
// MUL_N | N <= N*F
// MUL_D | D <= D*F, F <= 2-D*F, count iteration
// DONE  | one-cycle done pulse, results already registered
module goldschmidt_iter_ff
    import gd_pkg::*;
#(
    parameter int ITER = 5,
    parameter int FW   = 30
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [31:0]      A,
    input  logic [31:0]      B,
    output logic             busy,
    output logic             done,
    output logic             S_out,
    output logic [EXP_W-1:0] E_out,
    output logic [P_W-1:0]   P_out,
    output logic             dz,
    output logic             e_range
);

    localparam int QW = FW + 2;
    localparam int CW = $clog2(ITER) + 1;

    gd_state_e         state_q, state_d;
    logic [QW-1:0]     n_q, n_d, d_q, d_d, f_q, f_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              s_q, s_d, az_q, az_d, bz_q, bz_d;
    logic signed [9:0] ex_q, ex_d;
    logic              done_q, done_d, s_out_q, s_out_d, dz_q, dz_d, er_q, er_d;
    logic [EXP_W-1:0]  e_out_q, e_out_d;
    logic [P_W-1:0]    p_out_q, p_out_d;

    logic              sa, sb, za, zb;
    logic [EXP_W-1:0]  ea, eb;
    logic [MANT_W-1:0] ma, mb;

    fp_unpack u_unpack_a (.x_i(A), .sign_o(sa), .exp_o(ea), .mant_o(ma), .is_zero_o(za));
    fp_unpack u_unpack_b (.x_i(B), .sign_o(sb), .exp_o(eb), .mant_o(mb), .is_zero_o(zb));

    // Mantissa has 23 fraction bits; halving it gives 24, aligned up into FW fraction bits.
    logic [QW-1:0]     ma_half, mb_half;
    logic signed [9:0] ex_start;
    logic [47:0]       f_init_w, f_iter_w;
    logic [2*QW-1:0]   prod;
    logic [QW-1:0]     prod_t, mul_a;
    logic [P_W-1:0]    n_as_p;

    assign ma_half  = QW'(ma) << (FW - MANT_W);
    assign mb_half  = QW'(mb) << (FW - MANT_W);
    assign ex_start = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
    assign f_init_w = two_minus(48'(mb_half), FW);

    // Single multiplier shared between the numerator and denominator steps.
    assign mul_a    = (state_q == MUL_N) ? n_q : d_q;
    assign prod     = {{QW{1'b0}}, mul_a} * {{QW{1'b0}}, f_q};
    assign prod_t   = prod[2*FW+1:FW];
    assign f_iter_w = two_minus(48'(prod_t), FW);
    assign n_as_p   = P_W'(n_q) << (46 - FW);

    // Next-state, datapath and result selection.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        d_d     = d_q;
        f_d     = f_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        az_d    = az_q;
        bz_d    = bz_q;
        ex_d    = ex_q;
        done_d  = 1'b0;
        s_out_d = s_out_q;
        e_out_d = e_out_q;
        p_out_d = p_out_q;
        dz_d    = dz_q;
        er_d    = er_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = ma_half;
                    d_d     = mb_half;
                    f_d     = f_init_w[QW-1:0];
                    cnt_d   = '0;
                    s_d     = sa ^ sb;
                    az_d    = za;
                    bz_d    = zb;
                    ex_d    = ex_start;
                    state_d = MUL_N;
                end
            end
            MUL_N: begin
                n_d     = prod_t;
                state_d = MUL_D;
            end
            MUL_D: begin
                d_d   = prod_t;
                f_d   = f_iter_w[QW-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    s_out_d = s_q;
                    dz_d    = 1'b0;
                    er_d    = 1'b0;
                    p_out_d = '0;
                    if (bz_q) begin
                        dz_d    = 1'b1;
                        e_out_d = 8'hFF;
                    end else if (az_q) begin
                        e_out_d = 8'h00;
                    end else if (ex_q < 10'sd1) begin
                        er_d    = 1'b1;
                        e_out_d = 8'h00;
                    end else if (ex_q > 10'sd254) begin
                        er_d    = 1'b1;
                        e_out_d = 8'hFF;
                    end else begin
                        e_out_d = ex_q[7:0];
                        p_out_d = n_as_p;
                    end
                end else begin
                    state_d = MUL_N;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; clr abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            n_q     <= '0;
            d_q     <= '0;
            f_q     <= '0;
            cnt_q   <= '0;
            s_q     <= 1'b0;
            az_q    <= 1'b0;
            bz_q    <= 1'b0;
            ex_q    <= '0;
            done_q  <= 1'b0;
            s_out_q <= 1'b0;
            e_out_q <= '0;
            p_out_q <= '0;
            dz_q    <= 1'b0;
            er_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            f_q     <= f_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            az_q    <= az_d;
            bz_q    <= bz_d;
            ex_q    <= ex_d;
            done_q  <= done_d;
            s_out_q <= s_out_d;
            e_out_q <= e_out_d;
            p_out_q <= p_out_d;
            dz_q    <= dz_d;
            er_q    <= er_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign S_out   = s_out_q;
    assign E_out   = e_out_q;
    assign P_out   = p_out_q;
    assign dz      = dz_q;
    assign e_range = er_q;

endmodule
